// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, shift/rotate in either direction,
// and an automatic burst engine that reports busy/done.
// The register contents port is named dout because "do" is a reserved word.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pl,
  input  logic [WIDTH-1:0] di,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sir,
  input  logic             sil,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic [WIDTH-1:0] dout,
  output logic             so,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_SR = 3'b001;
  localparam logic [2:0] MODE_SL = 3'b010;
  localparam logic [2:0] MODE_RR = 3'b011;
  localparam logic [2:0] MODE_RL = 3'b100;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [2:0]       run_mode;
  logic [LEN_W-1:0] cnt;
  logic [WIDTH-1:0] q;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] nxt_q;
  logic             nxt_so;

  assign dout = q;

  // Result of one step; a burst uses its latched mode, a single step uses mode live
  always_comb begin
    step_mode = (state == RUN) ? run_mode : mode;
    nxt_q     = q;
    nxt_so    = so;
    case (step_mode)
      MODE_SR: begin
        nxt_q  = {sir, q[WIDTH-1:1]};
        nxt_so = q[0];
      end
      MODE_SL: begin
        nxt_q  = {q[WIDTH-2:0], sil};
        nxt_so = q[WIDTH-1];
      end
      MODE_RR: begin
        nxt_q  = {q[0], q[WIDTH-1:1]};
        nxt_so = q[0];
      end
      MODE_RL: begin
        nxt_q  = {q[WIDTH-2:0], q[WIDTH-1]};
        nxt_so = q[WIDTH-1];
      end
      default: ;
    endcase
  end

  // Register, burst FSM and handshake outputs; pl overrides and aborts any burst
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      run_mode <= 3'b000;
      cnt      <= '0;
      q        <= '0;
      so       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pl) begin
        q     <= di;
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            q   <= nxt_q;
            so  <= nxt_so;
            cnt <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: begin
            if (start) begin
              if (len != '0) begin
                run_mode <= mode;
                cnt      <= len;
                state    <= RUN;
                busy     <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end else if (en) begin
              q  <= nxt_q;
              so <= nxt_so;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=4: expected outputs are queued as
// each stimulus step is driven and checked one edge later.
module tb_univ_shift_reg;

  localparam int unsigned W = 4;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pl;
  logic [W-1:0]  di;
  logic          en;
  logic [2:0]    mode;
  logic          sir;
  logic          sil;
  logic          start;
  logic [LW-1:0] len;
  logic [W-1:0]  dout;
  logic          so;
  logic          busy;
  logic          done;

  typedef struct {
    string        tag;
    logic [W-1:0] e_do;
    logic         e_so;
    logic         e_busy;
    logic         e_done;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  univ_shift_reg #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .pl(pl), .di(di), .en(en), .mode(mode),
    .sir(sir), .sil(sil), .start(start), .len(len),
    .dout(dout), .so(so), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Compare one observed field against its expected value
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Queue the expectation for the next edge, take the edge, then pop and check
  task automatic cycle(input string tag, input logic [W-1:0] e_do, input logic e_so,
                       input logic e_busy, input logic e_done);
    exp_t e;
    exp_q.push_back('{tag, e_do, e_so, e_busy, e_done});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, ".do"},   dout,              e.e_do);
    chk({e.tag, ".so"},   W'(so),            W'(e.e_so));
    chk({e.tag, ".busy"}, W'(busy),          W'(e.e_busy));
    chk({e.tag, ".done"}, W'(done),          W'(e.e_done));
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pl = 1'b0; di = '0; en = 1'b0; mode = 3'b000;
    sir = 1'b0; sil = 1'b0; start = 1'b0; len = '0;
    #12;
    chk("rst.do", dout, 4'b0000);
    chk("rst.so", W'(so), W'(1'b0));
    chk("rst.busy", W'(busy), W'(1'b0));
    chk("rst.done", W'(done), W'(1'b0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Load and single steps
    pl = 1'b1; di = 4'b1010;
    cycle("load", 4'b1010, 1'b0, 1'b0, 1'b0);
    pl = 1'b0; en = 1'b1; mode = 3'b001; sir = 1'b1;
    cycle("step_sr", 4'b1101, 1'b0, 1'b0, 1'b0);
    mode = 3'b010; sil = 1'b0;
    cycle("step_sl", 4'b1010, 1'b1, 1'b0, 1'b0);
    mode = 3'b011;
    cycle("step_rr", 4'b0101, 1'b0, 1'b0, 1'b0);
    mode = 3'b111;
    cycle("step_hold7", 4'b0101, 1'b0, 1'b0, 1'b0);
    en = 1'b0;

    // Burst rotate left, len=3
    pl = 1'b1; di = 4'b1000;
    cycle("pl1000", 4'b1000, 1'b0, 1'b0, 1'b0);
    pl = 1'b0; start = 1'b1; mode = 3'b100; len = 4'd3;
    cycle("rl_start", 4'b1000, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    cycle("rl_1", 4'b0001, 1'b1, 1'b1, 1'b0);
    cycle("rl_2", 4'b0010, 1'b0, 1'b1, 1'b0);
    cycle("rl_3", 4'b0100, 1'b0, 1'b0, 1'b1);
    cycle("rl_after", 4'b0100, 1'b0, 1'b0, 1'b0);

    // SISO burst shift right with sir=1; mode/len changes mid-burst ignored
    pl = 1'b1; di = 4'b0000;
    cycle("pl0000", 4'b0000, 1'b0, 1'b0, 1'b0);
    pl = 1'b0; start = 1'b1; mode = 3'b001; len = 4'd4; sir = 1'b1;
    cycle("sr_start", 4'b0000, 1'b0, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b010; len = 4'd1;
    cycle("sr_1", 4'b1000, 1'b0, 1'b1, 1'b0);
    mode = 3'b000; len = 4'd9;
    cycle("sr_2", 4'b1100, 1'b0, 1'b1, 1'b0);
    cycle("sr_3", 4'b1110, 1'b0, 1'b1, 1'b0);
    cycle("sr_4", 4'b1111, 1'b0, 1'b0, 1'b1);

    // Back-to-back start while done=1; en/start during the burst are ignored
    start = 1'b1; mode = 3'b011; len = 4'd2; sir = 1'b0;
    cycle("b2b_start", 4'b1111, 1'b0, 1'b1, 1'b0);
    en = 1'b1; mode = 3'b001; len = 4'd5;
    cycle("ign_1", 4'b1111, 1'b1, 1'b1, 1'b0);
    cycle("ign_2", 4'b1111, 1'b1, 1'b0, 1'b1);
    en = 1'b0; start = 1'b0;

    // Zero-length burst
    start = 1'b1; len = 4'd0; mode = 3'b001;
    cycle("len0", 4'b1111, 1'b1, 1'b0, 1'b1);
    start = 1'b0;
    cycle("len0_after", 4'b1111, 1'b1, 1'b0, 1'b0);

    // Abort a len=5 burst with pl on the second shift edge
    pl = 1'b1; di = 4'b0011;
    cycle("pl0011", 4'b0011, 1'b1, 1'b0, 1'b0);
    pl = 1'b0; start = 1'b1; mode = 3'b010; len = 4'd5; sil = 1'b0;
    cycle("ab_start", 4'b0011, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    cycle("ab_1", 4'b0110, 1'b0, 1'b1, 1'b0);
    pl = 1'b1; di = 4'b0110;
    cycle("ab_pl", 4'b0110, 1'b0, 1'b0, 1'b0);
    pl = 1'b0;
    cycle("ab_idle1", 4'b0110, 1'b0, 1'b0, 1'b0);
    cycle("ab_idle2", 4'b0110, 1'b0, 1'b0, 1'b0);

    // Reset mid-burst clears outputs without waiting for an edge
    start = 1'b1; mode = 3'b100; len = 4'd5;
    cycle("rb_start", 4'b0110, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    cycle("rb_1", 4'b1100, 1'b0, 1'b1, 1'b0);
    cycle("rb_2", 4'b1001, 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("rb_rst.do", dout, 4'b0000);
    chk("rb_rst.so", W'(so), W'(1'b0));
    chk("rb_rst.busy", W'(busy), W'(1'b0));
    chk("rb_rst.done", W'(done), W'(1'b0));
    @(posedge clk); #1;
    reset = 1'b0;
    cycle("rb_after1", 4'b0000, 1'b0, 1'b0, 1'b0);
    cycle("rb_after2", 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
